pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Controls the FPGA clock PLL and the board-level reset. It runs on the free-running board input clock, which also feeds the PLL reference input. It pulses the PLL's asynchronous reset and waits for lock. It holds the system reset until lock has been stable for a programmed time, then recovers automatically from lock loss, lock timeout or a software reset request. It sits between the board clock/reset pins and the PLL instance, and its reset output drives the core reset synchronizers.

## Interface
- ARESET_CYCLES, 16: cycles `pll_areset` is held high per PLL reset pulse (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before releasing `sys_rst` (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK before the PLL is reset again (≥1).
- EVT_CNT_W, 8: width of the saturating event counters.
- clk  in  1  board input clock, free-running; same net as the PLL `inclk0`.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL `locked`, asynchronous to `clk`; synchronized internally.
- sw_reset_req  in  1  single-cycle request to restart the full PLL/reset sequence.
- pll_areset  out  1  drives the PLL `areset`; registered.
- sys_rst  out  1  active-high system reset to the core; registered.
- seq_ready  out  1  high only in RUN; registered.
- lock_loss_cnt  out  EVT_CNT_W  number of lock losses seen in RUN; saturating.
- timeout_cnt  out  EVT_CNT_W  number of WAIT_LOCK timeouts; saturating.

## Operation
- The `pll_locked` input passes through a 2-flop synchronizer, giving `lock_s`. The state machine uses only `lock_s`.
- A single down-counter is shared by all states. It is wide enough for the largest parameter and is reloaded on every state entry.
- States and transitions:
  - RESET_PLL: `pll_areset`=1, `sys_rst`=1. Stays for ARESET_CYCLES cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK: `pll_areset`=0, `sys_rst`=1.
    - If `lock_s`=1, go to STABLE.
    - If LOCK_TIMEOUT_CYCLES cycles pass without lock, go to RESET_PLL and increment `timeout_cnt`.
  - STABLE: `sys_rst`=1. Counts consecutive `lock_s`=1 cycles.
    - If `lock_s`=0, go to WAIT_LOCK. The timeout counter reloads; `lock_loss_cnt` does not change.
    - After LOCK_STABLE_CYCLES cycles, go to RUN.
  - RUN: `sys_rst`=0, `seq_ready`=1.
    - If `lock_s`=0, go to RESET_PLL and increment `lock_loss_cnt`.
- `sw_reset_req` in any state forces RESET_PLL with a fresh ARESET_CYCLES pulse. It takes priority over every other transition. Neither event counter changes.
- Event counters saturate at all-ones. Only `rst` clears them.
- Outputs are decoded from the next state and registered, so each output changes in the same edge as the state change.

## Timing
- Reset values while `rst`=1: state RESET_PLL, `pll_areset`=1, `sys_rst`=1, `seq_ready`=0, both counters 0, synchronizer flops 0, down-counter loaded with ARESET_CYCLES.
- After `rst` falls, `pll_areset` stays high for exactly ARESET_CYCLES clock edges.
- Lock latency: a `pll_locked` rise reaches `lock_s` after 2 cycles and enters STABLE on the next edge.
- `sys_rst` falls exactly LOCK_STABLE_CYCLES cycles after STABLE entry, provided lock held throughout.
- Lock loss in RUN: `sys_rst` rises 3 cycles after `pll_locked` falls (2 synchronizer cycles + 1 register). `pll_areset` rises on the same edge.
- `sw_reset_req` is sampled directly, without synchronization. `pll_areset` and `sys_rst` are 1 on the next edge.
- Simultaneous `sw_reset_req` and `lock_s` loss in RUN: `sw_reset_req` wins, so `lock_loss_cnt` is not incremented.
- `rst` asserted mid-sequence: back to reset values on the next edge, and counters clear.
- Glitches on `pll_locked` shorter than 1 cycle may be missed. This is acceptable.

## Structure
- Package `pll_seq_pkg`: state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN) and a width-of-count helper function.
- Sub-module `sync_2ff`, a generic 1-bit 2-flop synchronizer with synchronous active-high reset to 0, used for `pll_locked`.
- One always block for state, counter and outputs; separate next-state logic.

## Test plan
Bench parameters: ARESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, EVT_CNT_W=2.
- Power-up: `rst` high for 3 cycles, then `pll_locked` rises 10 cycles later → `pll_areset` is high for exactly 4 cycles after `rst` falls, and `sys_rst` falls 2+1+8 cycles after the `pll_locked` rise.
- `pll_locked` never rises → `pll_areset` re-pulses every 4+32 cycles. `timeout_cnt` goes 1, 2, 3 and stays at 3 (saturated).
- `pll_locked` drops for 3 cycles midway through STABLE → return to WAIT_LOCK, `sys_rst` stays 1, and the stable count restarts from 8. `lock_loss_cnt` stays 0.
- `pll_locked` drops in RUN → `sys_rst` and `pll_areset` rise 3 cycles later, and `lock_loss_cnt` becomes 1. Relock releases `sys_rst` after the full sequence.
- `sw_reset_req` pulse in RUN, coincident with a lock drop → RESET_PLL on the next edge, and `lock_loss_cnt` is unchanged.
- `rst` pulsed during STABLE → all outputs return to reset values on the next edge, and the counters clear.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL / board reset sequencer.
//   pll_state_e : sequencer states
//   count_width : number of bits needed to hold a cycle count n
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // Smallest width w such that n fits in w bits (minimum 1).
  function automatic int unsigned count_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, synchronous active-high reset to 0.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output (2 cycles latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL areset pulse generator and system reset sequencer with lock supervision.
//   clk           : free-running board clock (also PLL reference)
//   rst           : synchronous active-high reset
//   pll_locked    : PLL lock, asynchronous, synchronized internally
//   sw_reset_req  : single-cycle request to restart the whole sequence
//   pll_areset    : PLL asynchronous reset, registered
//   sys_rst       : active-high core reset, registered
//   seq_ready     : high only in RUN, registered
//   lock_loss_cnt : saturating count of lock losses in RUN
//   timeout_cnt   : saturating count of WAIT_LOCK timeouts
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned ARESET_CYCLES       = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned EVT_CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 sw_reset_req,
  output logic                 pll_areset,
  output logic                 sys_rst,
  output logic                 seq_ready,
  output logic [EVT_CNT_W-1:0] lock_loss_cnt,
  output logic [EVT_CNT_W-1:0] timeout_cnt
);

  localparam int unsigned MAX_AS = (ARESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                   ARESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AS > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_AS : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = count_width(MAX_CYC);

  logic             lock_s;
  pll_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tmo_evt, loss_evt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Next state and shared down-counter; the counter is reloaded on every state entry
  // and the state is left when it reads 1, so a state lasts exactly its load value.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt - CNT_W'(1);
    tmo_evt  = 1'b0;
    loss_evt = 1'b0;
    if (sw_reset_req) begin
      state_n = RESET_PLL;
      cnt_n   = CNT_W'(ARESET_CYCLES);
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == CNT_W'(1)) begin
            state_n = WAIT_LOCK;
            cnt_n   = CNT_W'(LOCK_TIMEOUT_CYCLES);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_n = STABLE;
            cnt_n   = CNT_W'(LOCK_STABLE_CYCLES);
          end else if (cnt == CNT_W'(1)) begin
            state_n = RESET_PLL;
            cnt_n   = CNT_W'(ARESET_CYCLES);
            tmo_evt = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = CNT_W'(LOCK_TIMEOUT_CYCLES);
          end else if (cnt == CNT_W'(1)) begin
            state_n = RUN;
            cnt_n   = '0;
          end
        end
        RUN: begin
          cnt_n = cnt;
          if (!lock_s) begin
            state_n  = RESET_PLL;
            cnt_n    = CNT_W'(ARESET_CYCLES);
            loss_evt = 1'b1;
          end
        end
        default: begin
          state_n = RESET_PLL;
          cnt_n   = CNT_W'(ARESET_CYCLES);
        end
      endcase
    end
  end

  // State, counter, event counters and outputs; outputs decode the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_PLL;
      cnt           <= CNT_W'(ARESET_CYCLES);
      pll_areset    <= 1'b1;
      sys_rst       <= 1'b1;
      seq_ready     <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pll_areset <= (state_n == RESET_PLL);
      sys_rst    <= (state_n != RUN);
      seq_ready  <= (state_n == RUN);
      if (tmo_evt && (timeout_cnt != '1))
        timeout_cnt <= timeout_cnt + EVT_CNT_W'(1);
      if (loss_evt && (lock_loss_cnt != '1))
        lock_loss_cnt <= lock_loss_cnt + EVT_CNT_W'(1);
    end
  end

endmodule
